// File: rtl/mem_arb_pkg.sv
// Shared state/owner encodings and bus widths for the memory port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        I_RD = 2'd1,
        D_RD = 2'd2,
        D_WR = 2'd3
    } state_t;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_timeout.sv
// Busy watchdog: counts busy cycles since the last grant and flags the cycle
// in which the limit is reached.
module mem_arb_timeout #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic CLK,
    input  logic RESET,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // Saturates at the limit; the FSM leaves the busy state in that same cycle.
    always_ff @(posedge CLK) begin
        if (RESET || i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_expire = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates I-side reads and D-side reads/writes onto one block memory port,
// alternating grants on ties. Define MEM_ARB_TIMEOUT_EN to add a busy watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_data,
    output logic              i_valid,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_read_valid,
    input  logic              mem_write_valid,
    output logic              busy,
    output logic              timeout_err
);

    state_t            r_state;
    owner_t            r_last_grant;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_timeout_err;

    logic   w_i_req;
    logic   w_d_req;
    logic   w_grant;
    logic   w_rd_done;
    logic   w_wr_done;
    logic   w_done;
    logic   w_expire;
    owner_t w_owner;
    state_t w_next;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;
    assign w_grant = (r_state == IDLE) && (w_i_req || w_d_req);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_owner = OWNER_I;
        w_next  = IDLE;
        if (w_i_req && w_d_req) begin
            w_owner = (r_last_grant == OWNER_I) ? OWNER_D : OWNER_I;
        end else if (w_d_req) begin
            w_owner = OWNER_D;
        end
        // A simultaneous read+write on the D side is a writeback ahead of its refill.
        if (w_owner == OWNER_D) begin
            w_next = d_write ? D_WR : D_RD;
        end else if (w_i_req) begin
            w_next = I_RD;
        end
    end

    // Completions are suppressed while RESET is high so an aborted owner never sees a valid.
    assign w_rd_done = ((r_state == I_RD) || (r_state == D_RD)) && mem_read_valid && !RESET;
    assign w_wr_done = (r_state == D_WR) && mem_write_valid && !RESET;
    assign w_done    = w_rd_done || w_wr_done;

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK      (CLK),
        .RESET    (RESET),
        .i_clear  (w_grant),
        .i_enable (busy),
        .o_expire (w_expire)
    );
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign w_expire             = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_last_grant  <= OWNER_I;
            r_addr        <= '0;
            // NOTE: the wide write-data latch is reset too, so nothing stale is ever driven out.
            r_wdata       <= '0;
            r_mem_read    <= 1'b0;
            r_mem_write   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant) begin
                        r_state      <= w_next;
                        r_last_grant <= w_owner;
                        r_addr       <= (w_owner == OWNER_D) ? d_addr : i_addr;
                        if (w_next == D_WR) begin
                            r_wdata <= d_wdata;
                        end
                        r_mem_read   <= (w_next != D_WR);
                        r_mem_write  <= (w_next == D_WR);
                    end
                end
                default: begin
                    // A valid arriving in the expiry cycle wins over the watchdog.
                    if (w_done || w_expire) begin
                        r_state       <= IDLE;
                        r_mem_read    <= 1'b0;
                        r_mem_write   <= 1'b0;
                        r_timeout_err <= w_expire && !w_done;
                    end
                end
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign mem_read    = r_mem_read;
    assign mem_write   = r_mem_write;
    assign mem_addr    = busy ? r_addr : '0;
    assign mem_wdata   = r_mem_write ? r_wdata : '0;
    assign timeout_err = r_timeout_err;

    assign i_valid = w_rd_done && (r_state == I_RD);
    assign d_valid = (w_rd_done && (r_state == D_RD)) || w_wr_done;
    assign i_data  = i_valid ? mem_rdata : '0;
    assign d_rdata = (w_rd_done && (r_state == D_RD)) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter; timeout scenarios run when
// MEM_ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int TO_CYCLES = 8;

    localparam logic [255:0] P1  = {8{32'h1111_0001}};
    localparam logic [255:0] P2  = {8{32'h2222_0002}};
    localparam logic [255:0] P3  = {8{32'h3333_0003}};
    localparam logic [255:0] P4  = {8{32'h4444_0004}};
    localparam logic [255:0] P5  = {8{32'h5555_0005}};
    localparam logic [255:0] P6  = {8{32'hdead_beef}};
    localparam logic [255:0] P7  = {8{32'h7777_0007}};
    localparam logic [255:0] P8  = {8{32'h8888_0008}};
    localparam logic [255:0] P9  = {8{32'h9999_0009}};
    localparam logic [255:0] P10 = {8{32'haaaa_000a}};
    localparam logic [255:0] P11 = {8{32'hbbbb_000b}};

    logic         CLK = 1'b0;
    logic         RESET = 1'b1;
    logic         i_read = 1'b0;
    logic [31:0]  i_addr = '0;
    logic [255:0] i_data;
    logic         i_valid;
    logic         d_read = 1'b0;
    logic         d_write = 1'b0;
    logic [31:0]  d_addr = '0;
    logic [255:0] d_wdata = '0;
    logic [255:0] d_rdata;
    logic         d_valid;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_read_valid = 1'b0;
    logic         mem_write_valid = 1'b0;
    logic         busy;
    logic         timeout_err;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES(TO_CYCLES)
    ) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .i_read          (i_read),
        .i_addr          (i_addr),
        .i_data          (i_data),
        .i_valid         (i_valid),
        .d_read          (d_read),
        .d_write         (d_write),
        .d_addr          (d_addr),
        .d_wdata         (d_wdata),
        .d_rdata         (d_rdata),
        .d_valid         (d_valid),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .mem_read_valid  (mem_read_valid),
        .mem_write_valid (mem_write_valid),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic         side;      // 0 = I, 1 = D
        logic         chk_data;
        logic [255:0] data;
    } cpl_t;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } req_t;

    cpl_t cq[$];
    req_t mq[$];
    cpl_t mon_e;
    req_t mon_r;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    logic prev_busy = 1'b0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
    endtask

    task automatic expect_req(input logic wr, input logic [31:0] a, input logic [255:0] wd);
        req_t r;
        r.wr = wr;
        r.addr = a;
        r.wdata = wd;
        mq.push_back(r);
    endtask

    task automatic expect_cpl(input logic side, input logic chk, input logic [255:0] d);
        cpl_t c;
        c.side = side;
        c.chk_data = chk;
        c.data = d;
        cq.push_back(c);
    endtask

    // Memory returns read data for one cycle; the matching completion is expected.
    task automatic mem_rd_resp(input logic side, input logic [255:0] d);
        mem_read_valid = 1'b1;
        mem_rdata = d;
        expect_cpl(side, 1'b1, d);
        step();
        mem_read_valid = 1'b0;
        mem_rdata = '0;
    endtask

    // Monitor: pops completions on any valid, memory commands on each busy rise.
    always @(negedge CLK) begin
        if (mon_en) begin
            if (i_valid || d_valid) begin
                if (cq.size() == 0) begin
                    check("cpl_unexpected", {i_valid, d_valid}, '0);
                end else begin
                    mon_e = cq.pop_front();
                    check("cpl_side", {i_valid, d_valid}, mon_e.side ? 2'b01 : 2'b10);
                    if (mon_e.chk_data) begin
                        check("cpl_data", mon_e.side ? d_rdata : i_data, mon_e.data);
                    end
                end
            end
            if (!i_valid) check("i_data_zero", i_data, '0);
            if (!d_valid) check("d_rdata_zero", d_rdata, '0);
            if (!busy) check("mem_idle_zero", {mem_read, mem_write, mem_addr, mem_wdata[221:0]}, '0);
            if (busy && !prev_busy) begin
                if (mq.size() == 0) begin
                    check("mem_unexpected", {mem_read, mem_write}, '0);
                end else begin
                    mon_r = mq.pop_front();
                    check("mem_cmd", {mem_read, mem_write}, {!mon_r.wr, mon_r.wr});
                    check("mem_addr", mem_addr, mon_r.addr);
                    if (mon_r.wr) check("mem_wdata", mem_wdata, mon_r.wdata);
                end
            end
`ifndef MEM_ARB_TIMEOUT_EN
            check("timeout_err_zero", timeout_err, '0);
`endif
            prev_busy <= busy;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        // Reset state
        step();
        @(negedge CLK);
        check("rst_ctrl", {i_valid, d_valid, mem_read, mem_write, busy, timeout_err}, '0);
        check("rst_addr", mem_addr, '0);
        check("rst_wdata", mem_wdata, '0);
        check("rst_data", i_data | d_rdata, '0);
        step();
        RESET = 1'b0;
        mon_en = 1'b1;

        // Single I read, memory answers 5 cycles after mem_read
        i_read = 1'b1;
        i_addr = 32'h0040_0000;
        expect_req(1'b0, 32'h0040_0000, '0);
        @(negedge CLK);
        check("t1_lat_pre", mem_read, 1'b0);
        step();
        @(negedge CLK);
        check("t1_lat_mem_read", {mem_read, mem_addr}, {1'b1, 32'h0040_0000});
        repeat (5) step();
        i_read = 1'b0;
        mem_rd_resp(1'b0, P1);
        @(negedge CLK);
        check("t1_idle", busy, 1'b0);

        // Ties after reset: D first, then I, next tie D again
        apply_reset();
        i_read = 1'b1;
        i_addr = 32'h0040_0100;
        d_read = 1'b1;
        d_addr = 32'h1001_0000;
        expect_req(1'b0, 32'h1001_0000, '0);
        expect_req(1'b0, 32'h0040_0100, '0);
        step();
        @(negedge CLK);
        check("t2_first_d", {mem_read, mem_addr}, {1'b1, 32'h1001_0000});
        step();
        step();
        d_read = 1'b0;
        mem_rd_resp(1'b1, P2);
        @(negedge CLK);
        check("t2_gap_idle", busy, 1'b0);
        step();
        @(negedge CLK);
        check("t2_then_i", {mem_read, mem_addr}, {1'b1, 32'h0040_0100});
        step();
        i_read = 1'b0;
        mem_rd_resp(1'b0, P3);
        i_read = 1'b1;
        i_addr = 32'h0040_0200;
        d_read = 1'b1;
        d_addr = 32'h1001_0040;
        expect_req(1'b0, 32'h1001_0040, '0);
        expect_req(1'b0, 32'h0040_0200, '0);
        step();
        @(negedge CLK);
        check("t2_tie2_d", {mem_read, mem_addr}, {1'b1, 32'h1001_0040});
        step();
        d_read = 1'b0;
        mem_rd_resp(1'b1, P4);
        step();
        i_read = 1'b0;
        mem_rd_resp(1'b0, P5);

        // Read+write together is a write; read valids are ignored in D_WR
        d_read = 1'b1;
        d_write = 1'b1;
        d_addr = 32'h1001_0020;
        d_wdata = '1;
        expect_req(1'b1, 32'h1001_0020, '1);
        step();
        mem_read_valid = 1'b1;
        mem_rdata = P6;
        step();
        mem_read_valid = 1'b0;
        mem_rdata = '0;
        @(negedge CLK);
        check("t3_rd_valid_ignored", {busy, mem_write}, 2'b11);
        step();
        d_read = 1'b0;
        d_write = 1'b0;
        mem_write_valid = 1'b1;
        expect_cpl(1'b1, 1'b0, '0);
        step();
        mem_write_valid = 1'b0;
        @(negedge CLK);
        check("t3_done_idle", busy, 1'b0);

        // Address latched at grant; later d_addr changes are ignored
        d_read = 1'b1;
        d_addr = 32'h1001_0020;
        expect_req(1'b0, 32'h1001_0020, '0);
        step();
        d_addr = 32'h0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            check("t4_addr_hold", mem_addr, 32'h1001_0020);
            step();
        end
        d_read = 1'b0;
        mem_rd_resp(1'b1, P7);

        // Reset two cycles into I_RD aborts; held request is re-granted
        i_read = 1'b1;
        i_addr = 32'h0040_0040;
        expect_req(1'b0, 32'h0040_0040, '0);
        step();
        step();
        RESET = 1'b1;
        step();
        @(negedge CLK);
        check("t5_rst_ctrl", {i_valid, d_valid, mem_read, mem_write, busy, timeout_err}, '0);
        check("t5_rst_addr", mem_addr, '0);
        expect_req(1'b0, 32'h0040_0040, '0);
        step();
        RESET = 1'b0;
        step();
        @(negedge CLK);
        check("t5_regrant", mem_read, 1'b1);
        step();
        i_read = 1'b0;
        mem_rd_resp(1'b0, P8);

        // Request held through completion: one IDLE cycle, then re-granted
        i_read = 1'b1;
        i_addr = 32'h0040_0080;
        expect_req(1'b0, 32'h0040_0080, '0);
        expect_req(1'b0, 32'h0040_0080, '0);
        step();
        mem_rd_resp(1'b0, P9);
        @(negedge CLK);
        check("t6_gap", busy, 1'b0);
        step();
        i_read = 1'b0;
        mem_rd_resp(1'b0, P10);

`ifdef MEM_ARB_TIMEOUT_EN
        // No memory response: abort after TO_CYCLES busy cycles
        i_read = 1'b1;
        i_addr = 32'h0040_00c0;
        expect_req(1'b0, 32'h0040_00c0, '0);
        step();
        for (int k = 1; k < TO_CYCLES; k++) begin
            @(negedge CLK);
            check("t7_waiting", {busy, timeout_err}, 2'b10);
            step();
        end
        @(negedge CLK);
        check("t7_last_busy", {busy, timeout_err}, 2'b10);
        i_read = 1'b0;
        step();
        @(negedge CLK);
        check("t7_terr_pulse", {busy, timeout_err}, 2'b01);
        step();
        @(negedge CLK);
        check("t7_terr_once", {busy, timeout_err}, 2'b00);

        // Valid in the limit cycle completes normally
        i_read = 1'b1;
        expect_req(1'b0, 32'h0040_00c0, '0);
        step();
        repeat (TO_CYCLES - 1) step();
        i_read = 1'b0;
        mem_rd_resp(1'b0, P11);
        @(negedge CLK);
        check("t8_no_terr", {busy, timeout_err}, 2'b00);
        step();
        @(negedge CLK);
        check("t8_no_terr_late", timeout_err, 1'b0);
`endif

        repeat (3) step();
        check("cq_drained", cq.size(), 0);
        check("mq_drained", mq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
